gpr_bank: RTL
=============

# gpr_bank

Parametrised general-purpose register bank for the datapath: configurable width and depth, two write ports, two combinational read ports, optional write-to-read bypass and a per-register busy scoreboard. Multi-cycle units reserve a destination register and release it on write-back. Replaces the fixed 32×32 single-write-port register file and adds reset, dual write and hazard tracking.

## Interface
- DW, 32, data width in bits
- AW, 5, address width; depth = 2^AW registers
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes busy
- BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (priority port)
- wa1  in  AW  write address, port 1
- wd1  in  DW  write data, port 1
- rsv  in  1  reserve request: mark rsv_a busy
- rsv_a  in  AW  register to reserve
- rsv_err  out  1  registered; pulses 1 cycle when rsv targeted an already-busy register
- ra  in  AW  read address A
- rda  out  DW  read data A (combinational)
- busy_a  out  1  busy flag of ra (combinational)
- rb  in  AW  read address B
- rdb  out  DW  read data B (combinational)
- busy_b  out  1  busy flag of rb (combinational)

## Operation
- State: regs[2^AW] of DW bits, busy[2^AW] bits, rsv_err flop.
- Write: on edge, if weN, regs[waN] <= wdN and busy[waN] <= 0.
- Dual-write collision (we0 & we1 & wa0 == wa1): port 1 data stored; port 0 discarded.
- Reserve: if rsv, busy[rsv_a] <= 1. Reserve and write to the same address in the same cycle: data written, busy ends 1 (reserve wins; new pending result).
- rsv_err <= rsv & busy[rsv_a] (pre-edge value, ignoring same-cycle writes); the reservation still takes effect.
- ZERO_REG=1: writes and reserves to address 0 ignored; rda/rdb = 0 and busy_a/busy_b = 0 for address 0, including under bypass; rsv_err never set for address 0.
- Read, BYPASS=0: rda = regs[ra], busy_a = busy[ra] (pre-edge state).
- Read, BYPASS=1: if we1 & wa1 == ra then rda = wd1; else if we0 & wa0 == ra then rda = wd0; else regs[ra]. busy_a = busy[ra] & ~(matching write) | (rsv & rsv_a == ra is NOT forwarded; reservation visible next cycle). Port B identical with rb.
- Reset: all regs 0, all busy 0, rsv_err 0. During rst, writes and reserves ignored; read ports show reset-cleared state from the following cycle (rda/rdb/busy = 0 for all addresses after the reset edge).

## Timing
- Write latency: data visible at read port the cycle after the write edge (BYPASS=0), or same cycle combinationally (BYPASS=1).
- Busy set: visible the cycle after rsv edge. Busy clear: cycle after write edge, same cycle with BYPASS=1.
- rsv_err: asserted exactly one cycle, the cycle after the offending rsv edge.
- Reset takes effect at the first rising edge with rst=1; outputs derived from state read 0 from then until written.
- No throughput limit: two writes, one reserve and two reads every cycle.

## Test plan
- Reset: preload regs 3 = 0xDEADBEEF and busy[3]; assert rst one cycle -> rda(ra=3) = 0, busy_a = 0, rsv_err = 0.
- Write/read: we0, wa0=5, wd0=0x12345678; next cycle ra=5 -> rda = 0x12345678; BYPASS=1 same cycle rda = 0x12345678, BYPASS=0 same cycle rda = old value.
- Collision: we0 wa0=7 wd0=0xAAAA_AAAA, we1 wa1=7 wd1=0x5555_5555 -> next cycle rdb(rb=7) = 0x55555555.
- Zero register: we1 wa1=0 wd1=0xFFFFFFFF, rsv rsv_a=0 -> rda(ra=0) = 0, busy_a = 0, rsv_err = 0 next cycle.
- Scoreboard: rsv rsv_a=9 -> next cycle busy_a(ra=9)=1; rsv rsv_a=9 again -> rsv_err=1 one cycle; we0 wa0=9 -> busy_a=0 same cycle (BYPASS=1) / next cycle (BYPASS=0).
- Reserve+write same cycle to 12 with wd0=0x0F0F0F0F -> next cycle rda(ra=12)=0x0F0F0F0F and busy_a=1.

Source files
------------

// File: rtl/gpr_bank.sv
// gpr_bank: parametrised general-purpose register bank with two write ports,
// two combinational read ports, optional write-to-read bypass and a
// per-register busy scoreboard for multi-cycle result tracking.
//
// Parameters
//   DW       data width
//   AW       address width, depth = 2**AW
//   ZERO_REG 1 = register 0 is hard-wired to zero and never busy
//   BYPASS   1 = same-cycle write data / busy-clear forwarded to read ports
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1 (wins on address collision)
//   rsv/rsv_a         reserve request: mark rsv_a busy
//   rsv_err           registered, reserve hit an already-busy register
//   ra/rda/busy_a     read port A (combinational)
//   rb/rdb/busy_b     read port B (combinational)
module gpr_bank #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic          rsv,
    input  logic [AW-1:0] rsv_a,
    output logic          rsv_err,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rda,
    output logic          busy_a,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] rdb,
    output logic          busy_b
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0]    regs_q [Depth];
    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;
    logic             rsv_err_q;

    // Qualified requests: suppressed during reset and, with ZERO_REG, for address 0.
    logic we0_eff;
    logic we1_eff;
    logic rsv_eff;

    assign we0_eff = we0 & ~rst & ~(ZERO_REG && (wa0 == '0));
    assign we1_eff = we1 & ~rst & ~(ZERO_REG && (wa1 == '0));
    assign rsv_eff = rsv & ~rst & ~(ZERO_REG && (rsv_a == '0));

    // Writes clear busy; a same-cycle reserve is applied last so it wins,
    // since it marks a new pending result for that register.
    always_comb begin
        busy_d = busy_q;
        if (we0_eff) busy_d[wa0] = 1'b0;
        if (we1_eff) busy_d[wa1] = 1'b0;
        if (rsv_eff) busy_d[rsv_a] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            if (we0_eff) regs_q[wa0] <= wd0;
            // Port 1 assigned last so it overrides port 0 on a collision.
            if (we1_eff) regs_q[wa1] <= wd1;
            busy_q    <= busy_d;
            // Uses pre-edge busy, ignoring any same-cycle write.
            rsv_err_q <= rsv_eff & busy_q[rsv_a];
        end
    end

    assign rsv_err = rsv_err_q;

    // Read ports, evaluated identically for A and B.
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rdata [2];
    logic          rbusy [2];

    assign raddr[0] = ra;
    assign raddr[1] = rb;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs_q[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
            if (BYPASS) begin
                // A pending reserve is not forwarded; it shows up next cycle.
                if (we1_eff && (wa1 == raddr[p])) begin
                    rdata[p] = wd1;
                    rbusy[p] = 1'b0;
                end else if (we0_eff && (wa0 == raddr[p])) begin
                    rdata[p] = wd0;
                    rbusy[p] = 1'b0;
                end
            end
            if (ZERO_REG && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign rda    = rdata[0];
    assign busy_a = rbusy[0];
    assign rdb    = rdata[1];
    assign busy_b = rbusy[1];

endmodule
